stream_merge_rr: RTL

Parametrised N-channel byte-stream merger that drains several source FIFOs (SPI RX, UART RX, future peripherals) into one sink FIFO (UART TX) under round-robin arbitration with sink backpressure. It sits in the top level between the peripheral receive FIFOs and the transmit FIFO. It replaces ad-hoc priority echo logic, which drops a byte when two sources are ready in the same cycle. Every source byte is forwarded exactly once, in per-channel order, and the block never double-pops a source.

---
 rtl/stream_merge_rr.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stream_merge_rr.sv
// stream_merge_rr: drains CHANNELS first-word-fall-through byte sources into a
// single sink FIFO using round-robin arbitration. The sink's full flag applies
// backpressure. Each granted byte is popped exactly once and pushed exactly once.
//
// Optional feature: when STREAM_MERGE_TAG_EN is defined, every data byte is
// preceded by a tag byte of TAG_BASE | channel. When it is undefined, the sink
// sees raw bytes only and the TAG state and TAG_BASE parameter do not exist.
module stream_merge_rr #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
`ifdef STREAM_MERGE_TAG_EN
  , parameter logic [DATA_WIDTH-1:0] TAG_BASE = DATA_WIDTH'(8'hF0)
`endif
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            src_empty,
  input  logic [CHANNELS*DATA_WIDTH-1:0] src_data,
  output logic [CHANNELS-1:0]            src_read_en,
  input  logic                           sink_full,
  output logic                           sink_write_en,
  output logic [DATA_WIDTH-1:0]          sink_data,
  output logic [CH_BITS-1:0]             grant_channel,
  output logic                           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    SETTLE = 2'd2
`ifdef STREAM_MERGE_TAG_EN
    , TAG  = 2'd3
`endif
  } state_t;

  state_t                  state, state_next;
  logic [CH_BITS-1:0]      rr_ptr, rr_next;
  logic [CH_BITS-1:0]      grant_next;
  logic                    write_next;
  logic [DATA_WIDTH-1:0]   data_next;
  logic [CHANNELS-1:0]     read_next;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [CHANNELS-1:0]     grant_onehot;
  logic [CH_BITS-1:0]      pick;
  logic                    any_ready;

  // The first non-empty channel strictly above ptr wins. If there is none,
  // the search wraps and the lowest non-empty channel at or below ptr wins.
  // The loop runs downward so that the lowest index in each half is assigned last.
  function automatic logic [CH_BITS-1:0] rr_pick(input logic [CHANNELS-1:0] empty,
                                                 input logic [CH_BITS-1:0]  ptr);
    logic [CH_BITS-1:0] hi;
    logic [CH_BITS-1:0] lo;
    logic               found_hi;
    hi       = '0;
    lo       = '0;
    found_hi = 1'b0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (!empty[c]) begin
        if (CH_BITS'(c) > ptr) begin
          hi       = CH_BITS'(c);
          found_hi = 1'b1;
        end else begin
          lo = CH_BITS'(c);
        end
      end
    end
    return found_hi ? hi : lo;
  endfunction

  assign any_ready = |(~src_empty);
  assign pick      = rr_pick(src_empty, rr_ptr);
  assign busy      = (state != IDLE);

  // Select the granted channel's head word and build its one-hot pop mask.
  always_comb begin
    head_data    = '0;
    grant_onehot = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant_channel == CH_BITS'(c)) begin
        head_data       = src_data[c*DATA_WIDTH +: DATA_WIDTH];
        grant_onehot[c] = 1'b1;
      end
    end
  end

  // Next-state logic. It also computes the registered strobes and data for the next cycle.
  always_comb begin
    // NOTE: every signal gets a default value before the case statement, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_next = state;
    rr_next    = rr_ptr;
    grant_next = grant_channel;
    write_next = 1'b0;
    data_next  = sink_data;
    read_next  = '0;
    case (state)
      IDLE: begin
        if (any_ready && !sink_full) begin
          grant_next = pick;
          rr_next    = pick;
`ifdef STREAM_MERGE_TAG_EN
          state_next = TAG;
`else
          state_next = DATA;
`endif
        end
      end
`ifdef STREAM_MERGE_TAG_EN
      TAG: begin
        if (!sink_full) begin
          write_next = 1'b1;
          data_next  = TAG_BASE | DATA_WIDTH'(grant_channel);
          state_next = DATA;
        end
      end
`endif
      DATA: begin
        if (!sink_full) begin
          write_next = 1'b1;
          data_next  = head_data;
          read_next  = grant_onehot;
          state_next = SETTLE;
        end
      end
      // Idle for one cycle so the popped source can update src_empty before
      // the next arbitration decision.
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered strobes and data. Reset is asynchronous.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= CH_BITS'(CHANNELS - 1);
      grant_channel <= '0;
      sink_write_en <= 1'b0;
      sink_data     <= '0;
      src_read_en   <= '0;
    end else begin
      // NOTE: use non-blocking assignments for every flop. All registers then
      // update together at the clock edge, whatever order these statements are in.
      state         <= state_next;
      rr_ptr        <= rr_next;
      grant_channel <= grant_next;
      sink_write_en <= write_next;
      sink_data     <= data_next;
      src_read_en   <= read_next;
    end
  end

endmodule
